// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its consumers.
package keypad_pkg;

    // Scanner FSM states.
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    // Active-low column strobe patterns, one per column index.
    localparam logic [3:0] COL0_SEL  = 4'b1110;
    localparam logic [3:0] COL1_SEL  = 4'b1101;
    localparam logic [3:0] COL2_SEL  = 4'b1011;
    localparam logic [3:0] COL3_SEL  = 4'b0111;

    // Row lines with no key pressed (pulled up).
    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    // Column index to active-low strobe pattern.
    function automatic logic [3:0] col_decode(input logic [1:0] col);
        logic [3:0] sel;
        case (col)
            2'd0:    sel = COL0_SEL;
            2'd1:    sel = COL1_SEL;
            2'd2:    sel = COL2_SEL;
            default: sel = COL3_SEL;
        endcase
        return sel;
    endfunction

    // Index of the lowest-numbered low row; rows must not be idle.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0])      idx = 2'd0;
        else if (!rows[1]) idx = 2'd1;
        else if (!rows[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

    // Key index {row, col} to the ASCII symbol printed on the calculator keycap.
    // Consumed by the calculator control logic, not by the scanner itself.
    function automatic logic [7:0] key_symbol(input logic [3:0] key);
        logic [7:0] sym;
        case (key)
            4'h0: sym = "1";
            4'h1: sym = "2";
            4'h2: sym = "3";
            4'h3: sym = "+";
            4'h4: sym = "4";
            4'h5: sym = "5";
            4'h6: sym = "6";
            4'h7: sym = "-";
            4'h8: sym = "7";
            4'h9: sym = "8";
            4'hA: sym = "9";
            4'hB: sym = "*";
            4'hC: sym = "C";
            4'hD: sym = "0";
            4'hE: sym = "=";
            default: sym = "/";
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/row_synchronizer.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
module row_synchronizer #(
    parameter int                    WIDTH       = 4,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two register stages; reset to the idle (released) pattern.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes one column per dwell period, samples the
// synchronized rows at the end of each dwell, and debounces press and release.
//
// Output handshake: key_valid is a one-cycle pulse with no back-pressure; the
// consumer must take key_code in the cycle key_valid is high (key_code also
// holds until the next accepted key).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_OVERFLOW  = 2**16-1,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_select,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam int CW = $clog2(SCAN_OVERFLOW + 1);
    localparam int SW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [CW-1:0] DWELL_LAST  = CW'(SCAN_OVERFLOW);
    localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE_TICKS - 1);

    logic [3:0]    row_s;
    logic [CW-1:0] dwell;
    logic          tick;

    // FSM state is kept as a named enum so it can be probed directly.
    scan_state_t   state, state_n;
    logic [1:0]    col, col_n;
    logic [1:0]    col_adv;
    logic [SW-1:0] stab, stab_n;
    logic [1:0]    cand_row, cand_row_n;
    logic [3:0]    col_select_n;
    logic [3:0]    key_code_n;
    logic          key_valid_n;
    logic          key_pressed_n;
    logic          cand_low;

    row_synchronizer #(
        .WIDTH       (4),
        .RESET_VALUE (ROWS_IDLE)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_in),
        .q     (row_s)
    );

    assign tick     = (dwell == DWELL_LAST);
    assign col_adv  = col + 2'd1;
    assign cand_low = !row_s[cand_row];

    // Free-running dwell counter; wraps after SCAN_OVERFLOW in every state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dwell <= '0;
        end else if (tick) begin
            dwell <= '0;
        end else begin
            dwell <= dwell + CW'(1);
        end
    end

    // Next-state and output logic; decisions are only taken on a dwell tick.
    always_comb begin
        state_n       = state;
        col_n         = col;
        col_select_n  = col_select;
        stab_n        = stab;
        cand_row_n    = cand_row;
        key_code_n    = key_code;
        key_valid_n   = 1'b0;
        key_pressed_n = key_pressed;

        if (tick) begin
            case (state)
                SCAN: begin
                    if (row_s != ROWS_IDLE) begin
                        // Park on this column and start confirming the press.
                        cand_row_n = lowest_low_row(row_s);
                        stab_n     = '0;
                        state_n    = DEBOUNCE;
                    end else begin
                        col_n        = col_adv;
                        col_select_n = col_decode(col_adv);
                    end
                end

                DEBOUNCE: begin
                    if (cand_low) begin
                        if (stab == STABLE_LAST) begin
                            key_code_n    = {cand_row, col};
                            key_valid_n   = 1'b1;
                            key_pressed_n = 1'b1;
                            stab_n        = '0;
                            state_n       = HELD;
                        end else begin
                            stab_n = stab + SW'(1);
                        end
                    end else begin
                        // Bounce: give up on this candidate and move on.
                        stab_n       = '0;
                        state_n      = SCAN;
                        col_n        = col_adv;
                        col_select_n = col_decode(col_adv);
                    end
                end

                HELD: begin
                    if (!cand_low) begin
                        if (stab == STABLE_LAST) begin
                            key_pressed_n = 1'b0;
                            stab_n        = '0;
                            state_n       = SCAN;
                            col_n         = col_adv;
                            col_select_n  = col_decode(col_adv);
                        end else begin
                            stab_n = stab + SW'(1);
                        end
                    end else begin
                        // Key still (or again) down: release must restart.
                        stab_n = '0;
                    end
                end

                default: begin
                    state_n = SCAN;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= SCAN;
            col         <= 2'd0;
            col_select  <= COL0_SEL;
            stab        <= '0;
            cand_row    <= 2'd0;
            key_code    <= 4'h0;
            key_valid   <= 1'b0;
            key_pressed <= 1'b0;
        end else begin
            state       <= state_n;
            col         <= col_n;
            col_select  <= col_select_n;
            stab        <= stab_n;
            cand_row    <= cand_row_n;
            key_code    <= key_code_n;
            key_valid   <= key_valid_n;
            key_pressed <= key_pressed_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a small keypad model and a
// queue-based scoreboard for key_valid/key_code.
module tb_keypad_scanner;

    localparam int SCAN_OVERFLOW  = 7;
    localparam int DEBOUNCE_TICKS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_select;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;

    // pressed[c] has bit r set when the key at row r, column c is held down.
    logic [3:0][3:0] pressed = '0;
    logic [1:0]      drv_col;

    logic [3:0] exp_q[$];
    int         n_compared   = 0;
    int         n_mismatched = 0;

    keypad_scanner #(
        .SCAN_OVERFLOW  (SCAN_OVERFLOW),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .row_in      (row_in),
        .col_select  (col_select),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_pressed (key_pressed)
    );

    // Clock.
    always #5 clk = ~clk;

    // Keypad matrix: a held key pulls its row low only while its column is strobed.
    always_comb begin
        case (col_select)
            4'b1110: drv_col = 2'd0;
            4'b1101: drv_col = 2'd1;
            4'b1011: drv_col = 2'd2;
            4'b0111: drv_col = 2'd3;
            default: drv_col = 2'd0;
        endcase
        row_in = (col_select == 4'b1110 || col_select == 4'b1101 ||
                  col_select == 4'b1011 || col_select == 4'b0111)
                 ? ~pressed[drv_col] : 4'b1111;
    end

    task automatic check(input string name, input int act, input int exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every key_valid pulse must match the oldest expected code.
    task automatic monitor();
        logic [3:0] exp;
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_mismatched++;
                    $display("FAIL unexpected_key_valid: got code %0h, no pulse expected", key_code);
                end else begin
                    exp = exp_q.pop_front();
                    if (key_code !== exp) begin
                        n_mismatched++;
                        $display("FAIL key_code_on_valid: got %0h, expected %0h", key_code, exp);
                    end
                end
            end
        end
    endtask

    // Wait until col_select newly enters the given pattern.
    task automatic wait_col_enter(input logic [3:0] target, input string name);
        int n = 0;
        while (col_select == target && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (col_select != target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(n < 200), 1);
    endtask

    // Wait for key_pressed to reach a level, bounded.
    task automatic wait_pressed(input logic level, input string name);
        int n = 0;
        while (key_pressed !== level && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(n < 200), 1);
    endtask

    // Number of consecutive sampled cycles col_select holds its current value.
    task automatic dwell_len(output int n);
        logic [3:0] cur;
        cur = col_select;
        n   = 0;
        while (col_select == cur && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col_select"}, int'(col_select), 32'hE);
        check({tag, "_key_code"}, int'(key_code), 0);
        check({tag, "_key_valid"}, int'(key_valid), 0);
        check({tag, "_key_pressed"}, int'(key_pressed), 0);
    endtask

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        fork
            monitor();
        join_none

        // Reset with no keys.
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        // Idle scanning: column 0 held through the reset cycle plus 7 more.
        @(negedge clk);
        dwell_len(n);
        check("dwell_col0_after_reset", n, 7);
        check("scan_col1", int'(col_select), 32'hD);
        dwell_len(n);
        check("dwell_col1", n, 8);
        check("scan_col2", int'(col_select), 32'hB);
        dwell_len(n);
        check("dwell_col2", n, 8);
        check("scan_col3", int'(col_select), 32'h7);
        dwell_len(n);
        check("dwell_col3", n, 8);
        check("scan_wrap_col0", int'(col_select), 32'hE);
        check("idle_key_pressed", int'(key_pressed), 0);

        // Row 2 held in column 1 -> key 9.
        pressed[1] = 4'b0100;
        exp_q.push_back(4'h9);
        wait_pressed(1'b1, "press_r2c1_accept");
        check("press_r2c1_code", int'(key_code), 32'h9);
        repeat (30) @(negedge clk);
        check("press_r2c1_col_held", int'(col_select), 32'hD);
        check("press_r2c1_still_pressed", int'(key_pressed), 1);
        pressed[1] = 4'b0000;
        wait_pressed(1'b0, "press_r2c1_release");
        check("press_r2c1_resume_col2", int'(col_select), 32'hB);

        // Bounce: row 2 low for a single tick in column 1.
        wait_col_enter(4'b1101, "bounce_reach_col1");
        pressed[1] = 4'b0100;
        repeat (8) @(negedge clk);
        check("bounce_col_parked", int'(col_select), 32'hD);
        pressed[1] = 4'b0000;
        repeat (7) @(negedge clk);
        check("bounce_col_still_parked", int'(col_select), 32'hD);
        @(negedge clk);
        check("bounce_resume_col2", int'(col_select), 32'hB);
        check("bounce_key_code_held", int'(key_code), 32'h9);
        check("bounce_not_pressed", int'(key_pressed), 0);

        // Rows 0 and 3 low in column 2 -> lowest row wins, key 2.
        pressed[2] = 4'b1001;
        exp_q.push_back(4'h2);
        wait_pressed(1'b1, "multi_row_accept");
        check("multi_row_code", int'(key_code), 32'h2);
        pressed[2] = 4'b0000;
        wait_pressed(1'b0, "multi_row_release");
        check("multi_row_resume_col3", int'(col_select), 32'h7);

        // Long hold: row 3 column 3 for 20 ticks, then release for 3 ticks.
        pressed[3] = 4'b1000;
        exp_q.push_back(4'hF);
        wait_pressed(1'b1, "long_hold_accept");
        repeat (20 * (SCAN_OVERFLOW + 1)) @(negedge clk);
        check("long_hold_pressed", int'(key_pressed), 1);
        check("long_hold_col_held", int'(col_select), 32'h7);
        check("long_hold_code", int'(key_code), 32'hF);
        pressed[3] = 4'b0000;
        repeat (3 * (SCAN_OVERFLOW + 1) - 1) @(negedge clk);
        check("release_before_third_tick", int'(key_pressed), 1);
        @(negedge clk);
        check("release_after_third_tick", int'(key_pressed), 0);
        check("release_resume_col0", int'(col_select), 32'hE);
        dwell_len(n);
        check("release_dwell_col0", n, 8);
        check("release_scan_col1", int'(col_select), 32'hD);

        // Reset in the middle of DEBOUNCE: row 1 column 0.
        wait_col_enter(4'b1110, "mid_reset_reach_col0");
        pressed[0] = 4'b0010;
        repeat (8) @(negedge clk);
        check("mid_reset_col_parked", int'(col_select), 32'hE);
        repeat (10) @(negedge clk);
        reset      = 1'b0;
        pressed[0] = 4'b0000;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        dwell_len(n);
        check("mid_reset_dwell_col0", n, 7);
        check("mid_reset_scan_col1", int'(col_select), 32'hD);
        repeat (40) @(negedge clk);
        check("mid_reset_no_press", int'(key_pressed), 0);

        check("all_expected_pulses_seen", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
